shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter RR_START, default 0, meaning the requester that wins the first tie after reset (0 or 1).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-004 The block SHALL have port flush, input, 1 bit: synchronous abort of any in-flight operation.
REQ-005 The block SHALL have ports rq0_valid and rq1_valid, input, 1 bit each: requester has an operation pending.
REQ-006 The block SHALL have ports rq0_ready and rq1_ready, output, 1 bit each: request accepted this cycle.
REQ-007 The block SHALL have ports rq0_op and rq1_op, input, 2 bits each: 00 SLL, 01 SRL, 10 SRA, 11 pass-through.
REQ-008 The block SHALL have ports rq0_a and rq1_a, input, 64 bits each: the operand.
REQ-009 The block SHALL have ports rq0_shamt and rq1_shamt, input, 6 bits each: the unsigned shift amount, 0..63.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port out_data, output, 64 bits: the shift result.
REQ-013 The block SHALL have port out_id, output, 1 bit: the index of the requester that owns the result.
REQ-014 The block SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-015 The block SHALL implement three states: IDLE, SHIFT and DONE.
REQ-016 In IDLE, with rst and flush both low, the block SHALL grant exactly one valid requester.
- Grant is signalled by asserting that requester's rqN_ready combinationally.
- rqN_ready SHALL be low in every other state.
REQ-017 Arbitration SHALL be round-robin.
- If only one requester is valid, that requester is granted.
- If both are valid, the requester not granted last is granted.
- After reset, "last granted" SHALL be !RR_START.
REQ-018 On the accepting edge the block SHALL register op, operand, shamt and id, clear stage counter k to 0, and enter SHIFT.
REQ-019 In SHIFT, each edge SHALL apply stage k: if shamt[k] is set, shift the working value by 2^k.
- SLL fills with 0.
- SRL fills with 0.
- SRA fills with operand bit 63.
- Pass-through leaves the value unchanged.
- k then increments.
REQ-020 After the stage k=5 edge the block SHALL enter DONE with out_valid high.
- Latency from the accepting edge to out_valid high is exactly 6 edges, independent of shamt.
REQ-021 In DONE, out_data and out_id SHALL hold stable until the edge where out_valid and out_ready are both high; the block then returns to IDLE.
REQ-022 No new request SHALL be accepted in the same cycle a result is consumed; the minimum issue interval is 8 cycles.
REQ-023 flush high in SHIFT or DONE SHALL return the block to IDLE on that edge and drop the result; out_valid is low the next cycle.
REQ-024 flush high in IDLE SHALL block acceptance that cycle (both rqN_ready low) and SHALL leave the round-robin pointer unchanged.
REQ-025 rst SHALL take priority over flush; flush SHALL take priority over all handshakes.
REQ-026 Shift amount 0 SHALL return the operand unchanged for all ops.

Reset
REQ-027 While rst is high, on each edge the block SHALL apply the following:
- state becomes IDLE;
- out_valid=0, busy=0, out_data=0, out_id=0, k=0;
- last-granted becomes !RR_START;
- rq0_ready and rq1_ready are held at 0 while rst is high.
REQ-028 rst asserted mid-operation SHALL discard the operation; no out_valid SHALL appear for it.

Verification
REQ-029 The bench SHALL cover: rq0 SRA, a=0x8000_0000_0000_0000, shamt=63 -> out_data=0xFFFF_FFFF_FFFF_FFFF, out_id=0, out_valid high exactly 6 edges after accept.
REQ-030 The bench SHALL cover: rq1 SRL, a=0x0000_0000_0000_00F0, shamt=4 -> 0x0F; rq0 SLL, a=0x1, shamt=0 -> 0x1.
REQ-031 The bench SHALL cover: both requesters valid continuously after reset with RR_START=0 -> grants in the order 0,1,0,1; each grant has an 8-cycle spacing when out_ready is tied high.
REQ-032 The bench SHALL cover: out_ready held low for 5 cycles in DONE -> out_valid, out_data and out_id remain stable; the block enters IDLE on the edge after out_ready rises.
REQ-033 The bench SHALL cover: flush asserted at k=3 -> busy low and out_valid never high for that request; the next request completes normally.
REQ-034 The bench SHALL cover: rst asserted in DONE -> all outputs are 0 the next cycle, and the first post-reset tie is granted to rq0.

Source files
------------

// File: rtl/shift_sequencer.sv
// Two-requester round-robin front end feeding a 6-stage log shifter (SLL/SRL/SRA/pass);
// one stage per clock, so latency is fixed regardless of shift amount.
module shift_sequencer #(
  parameter bit RR_START = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        rq0_valid,
  input  logic        rq1_valid,
  output logic        rq0_ready,
  output logic        rq1_ready,
  input  logic [1:0]  rq0_op,
  input  logic [1:0]  rq1_op,
  input  logic [63:0] rq0_a,
  input  logic [63:0] rq1_a,
  input  logic [5:0]  rq0_shamt,
  input  logic [5:0]  rq1_shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_id,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] data_q, data_d;
  logic [5:0]  shamt_q, shamt_d;
  logic        id_q, id_d;
  logic        last_q, last_d;

  logic        grant_any;
  logic        grant_id;
  logic [7:0]  shamt_ext;
  logic [5:0]  stage_amt;
  logic [63:0] stage_val;

  // Tie goes to whoever was not granted last; a lone requester always wins.
  always_comb begin
    grant_any = (state_q == IDLE) && !rst && !flush && (rq0_valid || rq1_valid);
    grant_id  = (rq0_valid && rq1_valid) ? ~last_q : rq1_valid;
    rq0_ready = grant_any && !grant_id;
    rq1_ready = grant_any && grant_id;
  end

  always_comb begin
    shamt_ext = {2'b00, shamt_q};
    stage_amt = 6'd1 << k_q;
    stage_val = data_q;
    if (shamt_ext[k_q]) begin
      case (op_q)
        2'b00:   stage_val = data_q << stage_amt;
        2'b01:   stage_val = data_q >> stage_amt;
        2'b10:   stage_val = 64'($signed(data_q) >>> stage_amt);
        default: stage_val = data_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    op_d    = op_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d = SHIFT;
          k_d     = '0;
          id_d    = grant_id;
          last_d  = grant_id;
          op_d    = grant_id ? rq1_op    : rq0_op;
          data_d  = grant_id ? rq1_a     : rq0_a;
          shamt_d = grant_id ? rq1_shamt : rq0_shamt;
        end
      end
      SHIFT: begin
        data_d = stage_val;
        if (k_q == 3'd5) begin
          state_d = DONE;
          k_d     = '0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) begin
      state_d = IDLE;
      k_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      op_q    <= '0;
      data_q  <= '0;
      shamt_q <= '0;
      id_q    <= 1'b0;
      last_q  <= ~RR_START;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      op_q    <= op_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: cycle-by-cycle transaction model of the shift sequencer,
// directed scenarios followed by randomized traffic with flush/reset injection.
module tb_shift_sequencer;

  localparam bit RR = 1'b0;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        rq0_valid, rq1_valid, rq0_ready, rq1_ready;
  logic [1:0]  rq0_op, rq1_op;
  logic [63:0] rq0_a, rq1_a;
  logic [5:0]  rq0_shamt, rq1_shamt;
  logic        out_valid, out_ready, out_id, busy;
  logic [63:0] out_data;

  shift_sequencer #(.RR_START(RR)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rq0_valid(rq0_valid), .rq1_valid(rq1_valid),
    .rq0_ready(rq0_ready), .rq1_ready(rq1_ready),
    .rq0_op(rq0_op), .rq1_op(rq1_op),
    .rq0_a(rq0_a), .rq1_a(rq1_a),
    .rq0_shamt(rq0_shamt), .rq1_shamt(rq1_shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // Transaction-level model: idle / waiting on a result / result presented.
  bit          m_idle, m_have, m_last, m_zero, m_id;
  int          m_wait;
  logic [63:0] m_res;
  int unsigned cyc = 0;
  int unsigned log_cyc[$];
  bit          log_id[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_shift(input logic [1:0] op, input logic [63:0] a,
                                            input logic [5:0] sh);
    logic signed [63:0] sa;
    sa = a;
    case (op)
      2'b00:   return a << sh;
      2'b01:   return a >> sh;
      2'b10:   return sa >>> sh;
      default: return a;
    endcase
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_have = 1'b0; m_wait = 0; m_last = !RR; m_zero = 1'b1; m_id = 1'b0;
  endtask

  // Called at a negedge with inputs already driven; checks, advances model, waits one cycle.
  task automatic step();
    bit exp_g, g_id;
    #1;
    exp_g = !rst && !flush && m_idle && (rq0_valid || rq1_valid);
    g_id  = (rq0_valid && rq1_valid) ? !m_last : rq1_valid;
    chk("rq0_ready", 64'(rq0_ready), 64'(exp_g && !g_id));
    chk("rq1_ready", 64'(rq1_ready), 64'(exp_g && g_id));
    chk("busy", 64'(busy), 64'(!m_idle));
    chk("out_valid", 64'(out_valid), 64'(m_have));
    if (m_have) begin
      chk("out_data", out_data, m_res);
      chk("out_id", 64'(out_id), 64'(m_id));
    end
    if (m_zero) begin
      chk("rst_data", out_data, 64'd0);
      chk("rst_id", 64'(out_id), 64'd0);
    end
    if (rst) model_reset();
    else if (flush && !m_idle) begin
      m_idle = 1'b1; m_have = 1'b0; m_wait = 0;
    end else if (exp_g) begin
      m_idle = 1'b0; m_wait = 6; m_last = g_id; m_id = g_id; m_zero = 1'b0;
      m_res  = g_id ? ref_shift(rq1_op, rq1_a, rq1_shamt) : ref_shift(rq0_op, rq0_a, rq0_shamt);
      log_cyc.push_back(cyc);
      log_id.push_back(g_id);
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_have = 1'b1;
    end else if (m_have && out_ready) begin
      m_have = 1'b0; m_idle = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_ops();
    rq0_op = 2'($urandom_range(0, 3));   rq1_op = 2'($urandom_range(0, 3));
    rq0_a  = {$urandom, $urandom};       rq1_a  = {$urandom, $urandom};
    rq0_shamt = 6'($urandom_range(0, 63)); rq1_shamt = 6'($urandom_range(0, 63));
  endtask

  task automatic issue(input bit id, input logic [1:0] op, input logic [63:0] a,
                       input logic [5:0] sh);
    if (id) begin rq1_valid = 1'b1; rq1_op = op; rq1_a = a; rq1_shamt = sh; end
    else    begin rq0_valid = 1'b1; rq0_op = op; rq0_a = a; rq0_shamt = sh; end
    step();
    rq0_valid = 1'b0; rq1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    rand_ops();
    @(negedge clk);
    model_reset();
    do_reset();

    // Both requesters valid from reset: expect strict alternation every 8 cycles.
    log_cyc.delete(); log_id.delete();
    rq0_valid = 1'b1; rq1_valid = 1'b1;
    for (int i = 0; i < 34; i++) begin
      rand_ops();
      step();
    end
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    chk("rr_count", 64'(log_id.size() >= 4), 64'd1);
    if (log_id.size() >= 4) begin
      chk("rr_g0", 64'(log_id[0]), 64'd0);
      chk("rr_g1", 64'(log_id[1]), 64'd1);
      chk("rr_g2", 64'(log_id[2]), 64'd0);
      chk("rr_g3", 64'(log_id[3]), 64'd1);
      for (int i = 1; i < 4; i++)
        chk("rr_spacing", 64'(log_cyc[i] - log_cyc[i-1]), 64'd8);
    end
    repeat (8) step();

    issue(1'b0, 2'b10, 64'h8000_0000_0000_0000, 6'd63);
    repeat (8) step();
    chk("sra63", m_res, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1'b1, 2'b01, 64'h0000_0000_0000_00F0, 6'd4);
    repeat (8) step();
    chk("srl4", m_res, 64'h0F);
    issue(1'b0, 2'b00, 64'h1, 6'd0);
    repeat (8) step();
    chk("sll0", m_res, 64'h1);

    // Consumer stalls five cycles in DONE.
    out_ready = 1'b0;
    issue(1'b1, 2'b00, {$urandom, $urandom}, 6'($urandom_range(1, 63)));
    repeat (11) step();
    out_ready = 1'b1;
    step();
    step();

    // Flush while stage k=3 is pending, then a clean request.
    issue(1'b0, 2'b01, 64'hDEAD_BEEF_0123_4567, 6'd37);
    repeat (3) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (8) step();
    issue(1'b1, 2'b10, 64'hF000_0000_0000_0010, 6'd5);
    repeat (8) step();

    // Reset while a result waits in DONE; first tie afterwards goes to rq0.
    out_ready = 1'b0;
    issue(1'b1, 2'b00, 64'h1234_5678_9ABC_DEF0, 6'd8);
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    log_id.delete();
    rq0_valid = 1'b1; rq1_valid = 1'b1;
    step();
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    chk("post_rst_tie", 64'(log_id.size() == 1 && log_id[0] == 1'b0), 64'd1);
    out_ready = 1'b1;
    repeat (8) step();

    for (int i = 0; i < 800; i++) begin
      rand_ops();
      rq0_valid = 1'($urandom_range(0, 1));
      rq1_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
